// File: rtl/seven_segment_pkg.sv
// Shared phase encoding and constants for the seven-segment scanner.
package seven_segment_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

    localparam int unsigned PWM_PERIOD = 15;
    localparam int unsigned PWM_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Slot/frame timing bus from the tick generator to the scanner datapath.
interface seven_segment_scanner_if #(
    parameter int unsigned SLOT_W = 3,
    parameter int unsigned IDX_W  = 2
) ();

    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic              slot_wrap;
    logic              frame_end;
    logic              frame_done;

    modport master (output slot_cnt, digit_idx, slot_wrap, frame_end, frame_done);
    modport slave  (input  slot_cnt, digit_idx, slot_wrap, frame_end, frame_done);

endinterface

// File: rtl/seven_segment_tick_gen.sv
// Slot counter, digit index and frame-done pulse for the seven-segment scanner.
module seven_segment_tick_gen #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 8
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    seven_segment_scanner_if.master tick
);

    localparam int unsigned SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic              frame_done;
    logic              slot_wrap_c;
    logic              frame_end_c;

    assign slot_wrap_c = (slot_cnt == SLOT_LAST);
    assign frame_end_c = slot_wrap_c && (digit_idx == IDX_LAST);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end_c;
            if (slot_wrap_c) begin
                slot_cnt  <= '0;
                digit_idx <= frame_end_c ? '0 : digit_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    assign tick.slot_cnt   = slot_cnt;
    assign tick.digit_idx  = digit_idx;
    assign tick.slot_wrap  = slot_wrap_c;
    assign tick.frame_end  = frame_end_c;
    assign tick.frame_done = frame_done;

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with anti-ghost blanking, PWM dimming and
// frame-coherent digit updates. Optional macro: SSD_LEADING_ZERO_SUPPRESS_EN.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_WIDTH  = 4,
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                              i_CLK,
    input  logic                              i_RST_N,
    input  logic                              i_LOAD,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] i_DIGITS,
    input  logic [NUM_DIGITS-1:0]             i_BLANK_MASK,
    input  logic [3:0]                        i_BRIGHTNESS,
    output logic [DIGIT_WIDTH-1:0]            o_OUT,
    output logic [NUM_DIGITS-1:0]             o_ANODES,
    output logic [$clog2(NUM_DIGITS)-1:0]     o_DIGIT_IDX,
    output logic                              o_FRAME_DONE
);

    localparam int unsigned SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned DATA_W = NUM_DIGITS * DIGIT_WIDTH;

    localparam logic [SLOT_W-1:0] BLANK_LAST =
        SLOT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [PWM_W-1:0]  PWM_LAST   = PWM_W'(PWM_PERIOD - 1);

    seven_segment_scanner_if #(.SLOT_W(SLOT_W), .IDX_W(IDX_W)) tick ();

    seven_segment_tick_gen #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV)
    ) u_tick_gen (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .tick    (tick)
    );

    phase_e                 phase;
    logic [PWM_W-1:0]       pwm_cnt;
    logic [DATA_W-1:0]      act_digits;
    logic [DATA_W-1:0]      pend_digits;
    logic [NUM_DIGITS-1:0]  act_mask;
    logic [NUM_DIGITS-1:0]  pend_mask;
    logic                   pend_valid;
    logic [NUM_DIGITS-1:0]  blank_c;
    logic [DIGIT_WIDTH-1:0] cur_code_c;
    logic [NUM_DIGITS-1:0]  anodes_c;

    // Phase tracks the slot counter: dark for the first BLANK_CYCLES of each slot.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            phase <= PH_BLANK;
        end else begin
            case (phase)
                PH_BLANK: if (BLANK_CYCLES == 0 || tick.slot_cnt == BLANK_LAST) phase <= PH_ON;
                PH_ON:    if (tick.slot_wrap && BLANK_CYCLES != 0)             phase <= PH_BLANK;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
        end
    end

    // Loads land in the shadow; the active copy only changes on a frame boundary.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            act_digits  <= '0;
            act_mask    <= '0;
            pend_digits <= '0;
            pend_mask   <= '0;
            pend_valid  <= 1'b0;
        end else if (tick.frame_end) begin
            if (i_LOAD) begin
                act_digits <= i_DIGITS;
                act_mask   <= i_BLANK_MASK;
            end else if (pend_valid) begin
                act_digits <= pend_digits;
                act_mask   <= pend_mask;
            end
            pend_valid <= 1'b0;
        end else if (i_LOAD) begin
            pend_digits <= i_DIGITS;
            pend_mask   <= i_BLANK_MASK;
            pend_valid  <= 1'b1;
        end
    end

`ifdef SSD_LEADING_ZERO_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] zero_sup_c;
    logic                  lead_zero_c;

    // Suppress the unbroken run of zero codes starting at digit 0; last digit always shown.
    always_comb begin
        zero_sup_c  = '0;
        lead_zero_c = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS) - 1; k++) begin
            lead_zero_c   = lead_zero_c && (act_digits[k*DIGIT_WIDTH +: DIGIT_WIDTH] == '0);
            zero_sup_c[k] = lead_zero_c;
        end
    end

    assign blank_c = act_mask | zero_sup_c;
`else
    assign blank_c = act_mask;
`endif

    always_comb begin
        cur_code_c = '0;
        anodes_c   = ANODES_OFF[NUM_DIGITS-1:0];
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (tick.digit_idx == IDX_W'(k)) begin
                cur_code_c = act_digits[k*DIGIT_WIDTH +: DIGIT_WIDTH];
                if (phase == PH_ON && !blank_c[k] && pwm_cnt < i_BRIGHTNESS) begin
                    anodes_c[int'(NUM_DIGITS) - 1 - k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_OUT       <= '0;
            o_ANODES    <= ANODES_OFF[NUM_DIGITS-1:0];
            o_DIGIT_IDX <= '0;
        end else begin
            o_OUT       <= cur_code_c;
            o_ANODES    <= anodes_c;
            o_DIGIT_IDX <= tick.digit_idx;
        end
    end

    assign o_FRAME_DONE = tick.frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 8 clocks/slot, 2 blank).
module tb_seven_segment_scanner;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  mask = '0;
    logic [3:0]  bright = 4'd15;
    logic [3:0]  o_out;
    logic [3:0]  o_anodes;
    logic [1:0]  o_idx;
    logic        o_fd;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference state: what the display should be holding, from the load rules.
    logic [15:0] m_act = '0;
    logic [3:0]  m_mask = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_pmask = '0;
    logic        m_pv = 1'b0;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS   (ND),
        .DIGIT_WIDTH  (4),
        .CLK_DIV      (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_LOAD       (load),
        .i_DIGITS     (digits),
        .i_BLANK_MASK (mask),
        .i_BRIGHTNESS (bright),
        .o_OUT        (o_out),
        .o_ANODES     (o_anodes),
        .o_DIGIT_IDX  (o_idx),
        .o_FRAME_DONE (o_fd)
    );

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  mask;
        logic [3:0]  lit;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [3:0] sup_mask(input logic [15:0] d);
        logic [3:0] s;
        s = '0;
`ifdef SSD_LEADING_ZERO_SUPPRESS_EN
        for (int k = 0; k < ND - 1; k++) begin
            if (d[k*4 +: 4] != 4'd0) break;
            s[k] = 1'b1;
        end
`endif
        return s;
    endfunction

    // One clock: predict outputs for the current cycle, advance, compare at negedge.
    task automatic step();
        int slot, idx, pwm;
        logic [3:0] code, sup, e_an;
        logic blk, lit, e_fd;
        slot = cyc % DIV;
        idx  = (cyc / DIV) % ND;
        pwm  = cyc % 15;
        code = m_act[idx*4 +: 4];
        sup  = sup_mask(m_act);
        blk  = m_mask[idx] | sup[idx];
        lit  = (slot >= BLK) && !blk && (pwm < int'(bright));
        e_an = 4'hF;
        if (lit) e_an[ND-1-idx] = 1'b0;
        e_fd = ((cyc % FRAME) == FRAME - 1);
        if (e_fd) begin
            if (load) begin
                m_act  = digits;
                m_mask = mask;
            end else if (m_pv) begin
                m_act  = m_pend;
                m_mask = m_pmask;
            end
            m_pv = 1'b0;
        end else if (load) begin
            m_pend  = digits;
            m_pmask = mask;
            m_pv    = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("anodes", 32'(o_anodes), 32'(e_an));
        check("out", 32'(o_out), 32'(code));
        check("idx", 32'(o_idx), 32'(idx));
        check("frame_done", 32'(o_fd), 32'(e_fd));
        cyc++;
    endtask

    task automatic run_until(input int pos);
        for (int n = 0; n < FRAME && (cyc % FRAME) != pos; n++) step();
    endtask

    task automatic load_pulse(input logic [15:0] d, input logic [3:0] m);
        digits = d;
        mask   = m;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic check_at(input int pos, input logic [3:0] want, input string nm);
        run_until(pos);
        step();
        check(nm, 32'(o_out), 32'(want));
    endtask

    task automatic model_reset();
        cyc = 0;
        m_act = '0; m_mask = '0; m_pend = '0; m_pmask = '0; m_pv = 1'b0;
    endtask

    initial begin
        int lit_cnt, fd_cnt;
        logic [3:0] e_an;

        vecs[0] = '{16'h4321, 4'b0000, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b1001, 4'b0110};
`ifdef SSD_LEADING_ZERO_SUPPRESS_EN
        vecs[2] = '{16'h0300, 4'b0000, 4'b1100};
        vecs[3] = '{16'h0300, 4'b0010, 4'b1100};
        vecs[4] = '{16'h0000, 4'b0000, 4'b1000};
`else
        vecs[2] = '{16'h0300, 4'b0000, 4'b1111};
        vecs[3] = '{16'h0300, 4'b0010, 4'b1101};
        vecs[4] = '{16'h0000, 4'b0000, 4'b1111};
`endif
        vecs[5] = '{16'h9F0E, 4'b0100, 4'b1011};

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_anodes", 32'(o_anodes), 32'hF);
        check("rst_out", 32'(o_out), 32'h0);
        check("rst_idx", 32'(o_idx), 32'h0);
        check("rst_fd", 32'(o_fd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Table: each pattern becomes visible one frame boundary after loading
        for (int i = 0; i < NV; i++) begin
            bright = 4'd15;
            run_until(9);
            load_pulse(vecs[i].digits, vecs[i].mask);
            run_until(0);
            for (int k = 0; k < ND; k++) begin
                run_until(k*DIV + 4);
                step();
                check($sformatf("tbl%0d_out%0d", i, k), 32'(o_out), 32'(vecs[i].digits[k*4 +: 4]));
                e_an = 4'hF;
                if (vecs[i].lit[k]) e_an[ND-1-k] = 1'b0;
                check($sformatf("tbl%0d_an%0d", i, k), 32'(o_anodes), 32'(e_an));
            end
        end

        // Last load before the boundary wins
        run_until(3);
        load_pulse(16'h1111, 4'b0000);
        run_until(20);
        load_pulse(16'h2222, 4'b0000);
        check_at(4, 4'd2, "last_wins");

        // Load on the boundary cycle goes straight to the active digits
        run_until(10);
        load_pulse(16'h3333, 4'b0000);
        run_until(FRAME - 1);
        load_pulse(16'h5678, 4'b0000);
        check_at(4, 4'd8, "bnd_load_d0");
        check_at(12, 4'd7, "bnd_load_d1");
        check_at(4, 4'd8, "bnd_no_stale");

        // Mid-frame load does not disturb the frame in progress
        run_until(5);
        load_pulse(16'h4321, 4'b0000);
        check_at(4, 4'd1, "coh_d0");
        check_at(12, 4'd2, "coh_d1");
        run_until(18);
        load_pulse(16'h8765, 4'b0000);
        check_at(20, 4'd3, "coh_d2");
        check_at(28, 4'd4, "coh_d3");
        check_at(4, 4'd5, "coh_n0");
        check_at(12, 4'd6, "coh_n1");
        check_at(20, 4'd7, "coh_n2");
        check_at(28, 4'd8, "coh_n3");

        // Brightness 0 is dark; 8 lights 8 of every 15 ON cycles
        run_until(0);
        bright = 4'd0;
        lit_cnt = 0;
        for (int n = 0; n < 2*FRAME; n++) begin
            step();
            if (o_anodes != 4'hF) lit_cnt++;
        end
        check("bright0_lit", 32'(lit_cnt), 32'd0);
        bright = 4'd8;
        lit_cnt = 0;
        fd_cnt = 0;
        for (int n = 0; n < 480; n++) begin
            step();
            if (o_anodes != 4'hF) lit_cnt++;
            if (o_fd) fd_cnt++;
        end
        check("bright8_lit", 32'(lit_cnt), 32'd192);
        check("frame_done_cnt", 32'(fd_cnt), 32'd15);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                digits = 16'($urandom());
                mask   = 4'($urandom());
                load   = 1'b1;
            end
            if ($urandom_range(0, 31) == 0) bright = 4'($urandom_range(0, 15));
            step();
            load = 1'b0;
        end

        // Asynchronous reset in slot 2 with a load pending
        bright = 4'd15;
        run_until(5);
        load_pulse(16'h4321, 4'b0000);
        run_until(0);
        run_until(20);
        load_pulse(16'h9999, 4'b0000);
        check("pre_rst_an", 32'(o_anodes), 32'hD);
        #2 rst_n = 1'b0;
        #1;
        check("arst_anodes", 32'(o_anodes), 32'hF);
        check("arst_out", 32'(o_out), 32'h0);
        check("arst_idx", 32'(o_idx), 32'h0);
        check("arst_fd", 32'(o_fd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        check("post_rst_idx", 32'(o_idx), 32'h0);
        check("post_rst_out", 32'(o_out), 32'h0);
        run_until(0);
        check_at(12, 4'd0, "pend_discarded");
        check_at(28, 4'd0, "pend_discarded3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
